// File: rtl/l1_l2_request_arbiter.sv
// Round-robin arbiter that shares the core-to-L2 request port among the L1 icache, dcache and store queues,
// with a registered output slot and per-source outstanding-request credits.
module l1_l2_request_arbiter #(
  parameter int NUM_SRC         = 3,
  parameter int PACKET_WIDTH    = 600,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_SRC-1:0]              src_ready,
  input  logic [NUM_SRC*PACKET_WIDTH-1:0] src_packet,
  output logic [NUM_SRC-1:0]              src_ack,
  output logic                            l2_request_valid,
  output logic [PACKET_WIDTH-1:0]         l2_request_packet,
  output logic [1:0]                      l2_request_src,
  input  logic                            l2_ready,
  input  logic                            l2_response_valid,
  input  logic [1:0]                      l2_response_src,
  output logic [NUM_SRC-1:0]              src_credit_exhausted
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int SRC_W = 2;

  typedef enum logic {EMPTY, FULL} slot_t;

  slot_t              slot_state;
  logic [CNT_W-1:0]   count [NUM_SRC];
  logic [SRC_W-1:0]   rr_ptr;
  logic [SRC_W-1:0]   winner;
  logic               grant_vld;
  logic               can_accept;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] dec_vec;
  logic [NUM_SRC-1:0] empty_vec;
  logic [NUM_SRC-1:0] over_vec;

  assign l2_request_valid = (slot_state == FULL);
  assign can_accept       = !l2_request_valid || l2_ready;

  always_comb begin
    eligible             = '0;
    src_credit_exhausted = '0;
    dec_vec              = '0;
    empty_vec            = '0;
    over_vec             = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      eligible[i]             = src_ready[i] && (count[i] < CNT_W'(MAX_OUTSTANDING));
      src_credit_exhausted[i] = (count[i] == CNT_W'(MAX_OUTSTANDING));
      dec_vec[i]              = l2_response_valid && (l2_response_src == SRC_W'(i));
      empty_vec[i]            = (count[i] == '0);
      over_vec[i]             = (count[i] > CNT_W'(MAX_OUTSTANDING));
    end
  end

  // No grant while reset is held, so no source is acked for a request that the reset would discard.
  always_comb begin : arb
    int idx;
    grant_vld = 1'b0;
    winner    = '0;
    idx       = 0;
    if (!reset && can_accept) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        idx = (int'(rr_ptr) + k) % NUM_SRC;
        if (!grant_vld && eligible[idx[SRC_W-1:0]]) begin
          grant_vld = 1'b1;
          winner    = idx[SRC_W-1:0];
        end
      end
    end
  end

  assign src_ack = grant_vld ? (NUM_SRC'(1) << winner) : '0;

  // Output slot and round-robin pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_state        <= EMPTY;
      l2_request_packet <= '0;
      l2_request_src    <= '0;
      rr_ptr            <= '0;
    end else if (grant_vld) begin
      slot_state        <= FULL;
      l2_request_packet <= src_packet[int'(winner)*PACKET_WIDTH +: PACKET_WIDTH];
      l2_request_src    <= winner;
      rr_ptr            <= (winner == SRC_W'(NUM_SRC - 1)) ? '0 : winner + 1'b1;
    end else if (l2_ready) begin
      slot_state        <= EMPTY;
    end
  end

  // Credit counters: grant and response for the same source in one cycle cancel out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SRC; i++) count[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        case ({grant_vld && (winner == SRC_W'(i)), dec_vec[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  a_ack_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(src_ack));
  a_resp_src:   assert property (@(posedge clk) disable iff (reset)
                  l2_response_valid |-> (l2_response_src < SRC_W'(NUM_SRC)));
  a_resp_owed:  assert property (@(posedge clk) disable iff (reset) (dec_vec & empty_vec) == '0);
  a_cnt_bound:  assert property (@(posedge clk) disable iff (reset) over_vec == '0);

endmodule

// File: tb/tb_l1_l2_request_arbiter.sv
// Randomized bench for l1_l2_request_arbiter, checked cycle by cycle against a behavioural model
// of round-robin grants, the output slot and per-source credits.
module tb_l1_l2_request_arbiter;
  localparam int N   = 3;
  localparam int PW  = 600;
  localparam int MAX = 4;

  logic            clk;
  logic            reset;
  logic [N-1:0]    src_ready;
  logic [N*PW-1:0] src_packet;
  logic [N-1:0]    src_ack;
  logic            l2_request_valid;
  logic [PW-1:0]   l2_request_packet;
  logic [1:0]      l2_request_src;
  logic            l2_ready;
  logic            l2_response_valid;
  logic [1:0]      l2_response_src;
  logic [N-1:0]    src_credit_exhausted;

  l1_l2_request_arbiter #(.NUM_SRC(N), .PACKET_WIDTH(PW), .MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .reset(reset), .src_ready(src_ready), .src_packet(src_packet),
    .src_ack(src_ack), .l2_request_valid(l2_request_valid),
    .l2_request_packet(l2_request_packet), .l2_request_src(l2_request_src),
    .l2_ready(l2_ready), .l2_response_valid(l2_response_valid),
    .l2_response_src(l2_response_src), .src_credit_exhausted(src_credit_exhausted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int            m_cnt [N];
  int            m_ptr;
  bit            m_valid;
  logic [PW-1:0] m_pkt;
  int            m_src;
  bit            pend [N];
  logic [PW-1:0] spkt [N];
  int            e_win;
  bit            rsp_on;
  int            rsp_src;

  task automatic check_eq(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] rand_pkt();
    logic [639:0] t;
    for (int j = 0; j < 20; j++) t[j*32 +: 32] = $urandom;
    return t[PW-1:0];
  endfunction

  task automatic do_reset();
    reset             = 1'b1;
    l2_ready          = 1'b0;
    l2_response_valid = 1'b0;
    l2_response_src   = '0;
    #1;
    check_eq("rst_valid", PW'(l2_request_valid), '0);
    check_eq("rst_pkt",   l2_request_packet, '0);
    check_eq("rst_src",   PW'(l2_request_src), '0);
    check_eq("rst_exh",   PW'(src_credit_exhausted), '0);
    check_eq("rst_ack",   PW'(src_ack), '0);
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_ptr   = 0;
    m_valid = 1'b0;
    m_pkt   = '0;
    m_src   = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drive(input int p_req, input int p_rdy, input int p_rsp);
    int s0;
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && ($urandom % 100) < p_req) begin
        pend[i] = 1'b1;
        spkt[i] = rand_pkt();
      end
      src_ready[i]             = pend[i];
      src_packet[i*PW +: PW]   = spkt[i];
    end
    l2_ready = (($urandom % 100) < p_rdy);
    rsp_on   = 1'b0;
    rsp_src  = 0;
    if (($urandom % 100) < p_rsp) begin
      s0 = $urandom % N;
      for (int k = 0; k < N; k++)
        if (!rsp_on && m_cnt[(s0 + k) % N] > 0) begin
          rsp_on  = 1'b1;
          rsp_src = (s0 + k) % N;
        end
    end
    l2_response_valid = rsp_on;
    l2_response_src   = 2'(rsp_src);
  endtask

  task automatic check_cycle();
    logic [N-1:0] e_ack;
    logic [N-1:0] e_exh;
    bit can;
    can   = !m_valid || l2_ready;
    e_win = -1;
    if (can)
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (e_win < 0 && pend[j] && m_cnt[j] < MAX) e_win = j;
      end
    e_ack = '0;
    if (e_win >= 0) e_ack[e_win] = 1'b1;
    e_exh = '0;
    for (int i = 0; i < N; i++) e_exh[i] = (m_cnt[i] == MAX);
    check_eq("ack",   PW'(src_ack), PW'(e_ack));
    check_eq("valid", PW'(l2_request_valid), PW'(m_valid));
    check_eq("exh",   PW'(src_credit_exhausted), PW'(e_exh));
    if (m_valid) begin
      check_eq("pkt", l2_request_packet, m_pkt);
      check_eq("src", PW'(l2_request_src), PW'(m_src));
    end
  endtask

  task automatic update_model();
    if (e_win >= 0) begin
      m_cnt[e_win]++;
      pend[e_win] = 1'b0;
      m_ptr   = (e_win + 1) % N;
      m_valid = 1'b1;
      m_pkt   = spkt[e_win];
      m_src   = e_win;
    end else if (l2_ready) begin
      m_valid = 1'b0;
    end
    if (rsp_on) m_cnt[rsp_src]--;
  endtask

  int p_req [5] = '{50, 100, 90, 100, 70};
  int p_rdy [5] = '{100, 100, 30, 100, 70};
  int p_rsp [5] = '{50, 60, 40, 5, 30};

  initial begin
    src_ready         = '0;
    src_packet        = '0;
    l2_ready          = 1'b0;
    l2_response_valid = 1'b0;
    l2_response_src   = '0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      spkt[i] = '0;
    end
    do_reset();
    for (int ph = 0; ph < 5; ph++) begin
      for (int c = 0; c < 300; c++) begin
        if (ph == 2 && c == 150) do_reset();
        drive(p_req[ph], p_rdy[ph], p_rsp[ph]);
        #1;
        check_cycle();
        @(posedge clk);
        update_model();
        @(negedge clk);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
